// File: rtl/power_pkg.sv
// power_pkg: power-state encodings shared by power_mode_ctrl and its bench.
package power_pkg;
  localparam int PWR_STATE_W = 2;
  typedef enum logic [PWR_STATE_W-1:0] {
    OFF     = 2'd0,
    ARM_ON  = 2'd1,
    ON      = 2'd2,
    ARM_OFF = 2'd3
  } pwr_state_t;
endpackage

// File: rtl/sec_window_timer.sv
// sec_window_timer: seconds countdown from GESTURE_SEC, paced by tick; expire pulses on the final tick.
module sec_window_timer #(
  parameter int TICK_HZ     = 100,
  parameter int GESTURE_SEC = 5,
  parameter int SEC_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             clear,
  input  logic             tick,
  output logic [SEC_W-1:0] sec,
  output logic             expire
);
  localparam int SUB_W = TICK_HZ > 1 ? $clog2(TICK_HZ) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICK_HZ - 1);
  logic [SUB_W-1:0] sub;
  logic wrap;
  assign wrap   = sub == SUB_MAX;
  assign expire = tick && wrap && sec == SEC_W'(1);
  // Counting halts at zero so an unattended timer never wraps.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sec <= '0;
      sub <= '0;
    end else if (load) begin
      sec <= SEC_W'(GESTURE_SEC);
      sub <= '0;
    end else if (clear) begin
      sec <= '0;
      sub <= '0;
    end else if (tick && sec != '0) begin
      sub <= wrap ? '0 : sub + 1'b1;
      sec <= wrap ? sec - 1'b1 : sec;
    end
endmodule

// File: rtl/power_mode_ctrl.sv
// power_mode_ctrl: system power FSM merging the power_on level with left/right gesture keys.
// Define POWER_AUTO_OFF_EN to add an inactivity auto-off while ON.
module power_mode_ctrl
  import power_pkg::*;
#(
  parameter int TICK_HZ      = 100,
  parameter int GESTURE_SEC  = 5,
  parameter int AUTO_OFF_SEC = 60
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   tick,
  input  logic                   power_on,
  input  logic                   gesture_left,
  input  logic                   gesture_right,
  input  logic                   activity,
  output logic                   sys_on,
  output logic [PWR_STATE_W-1:0] pwr_state,
  output logic [3:0]             window_sec,
  output logic                   on_pulse,
  output logic                   off_pulse
);
  pwr_state_t state;
  logic power_on_d, rise, fall, l, r, auto_off, load, expire;
  logic [3:0] sec;
  assign rise       = power_on & ~power_on_d;
  assign fall       = ~power_on & power_on_d;
  assign l          = gesture_left & ~gesture_right;
  assign r          = gesture_right & ~gesture_left;
  assign sys_on     = state[1];
  assign pwr_state  = state;
  assign window_sec = state[0] ? sec : '0;
  // Left arms/restarts from the off side, right from the on side.
  assign load       = !rise && !fall && !auto_off && (sys_on ? r : l);
  sec_window_timer #(.TICK_HZ(TICK_HZ), .GESTURE_SEC(GESTURE_SEC), .SEC_W(4)) win_tmr (
    .clk, .reset, .load, .clear(!state[0]), .tick, .sec, .expire
  );
`ifdef POWER_AUTO_OFF_EN
  logic [6:0] idle_sec;
  logic idle_expire;
  sec_window_timer #(.TICK_HZ(TICK_HZ), .GESTURE_SEC(AUTO_OFF_SEC), .SEC_W(7)) idle_tmr (
    .clk, .reset,
    .load(state != ON || activity || gesture_left || gesture_right),
    .clear(1'b0), .tick, .sec(idle_sec), .expire(idle_expire)
  );
  assign auto_off = state == ON && idle_expire && idle_sec == 7'd1;
`else
  logic unused_idle;
  assign unused_idle = activity | (AUTO_OFF_SEC == 0);
  assign auto_off    = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= OFF;
      power_on_d <= 1'b0;
      on_pulse   <= 1'b0;
      off_pulse  <= 1'b0;
    end else begin
      power_on_d <= power_on;
      on_pulse   <= 1'b0;
      off_pulse  <= 1'b0;
      if (rise) begin
        state    <= ON;
        on_pulse <= !sys_on;
      end else if (fall) begin
        state     <= OFF;
        off_pulse <= sys_on;
      end else if (auto_off) begin
        state     <= OFF;
        off_pulse <= 1'b1;
      end else
        case (state)
          OFF:     if (l) state <= ARM_ON;
          ARM_ON:  if (r) begin
                     state    <= ON;
                     on_pulse <= 1'b1;
                   end else if (expire && !l) state <= OFF;
          ON:      if (r) state <= ARM_OFF;
          ARM_OFF: if (l) begin
                     state     <= OFF;
                     off_pulse <= 1'b1;
                   end else if (expire && !r) state <= ON;
        endcase
    end
endmodule

// File: tb/tb_power_mode_ctrl.sv
// tb_power_mode_ctrl: directed checks of power_mode_ctrl with TICK_HZ=100, GESTURE_SEC=5, AUTO_OFF_SEC=2.
module tb_power_mode_ctrl;
  logic clk = 0, reset = 0, tick = 0, power_on = 0;
  logic gesture_left = 0, gesture_right = 0, activity = 0;
  logic sys_on, on_pulse, off_pulse;
  logic [1:0] pwr_state;
  logic [3:0] window_sec;
  int checks = 0, errors = 0;

  power_mode_ctrl #(.TICK_HZ(100), .GESTURE_SEC(5), .AUTO_OFF_SEC(2)) dut (
    .clk(clk), .reset(reset), .tick(tick), .power_on(power_on),
    .gesture_left(gesture_left), .gesture_right(gesture_right), .activity(activity),
    .sys_on(sys_on), .pwr_state(pwr_state), .window_sec(window_sec),
    .on_pulse(on_pulse), .off_pulse(off_pulse)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick = 1;
      cyc();
      tick = 0;
      cyc();
    end
  endtask

  task automatic left();
    gesture_left = 1;
    cyc();
    gesture_left = 0;
  endtask

  task automatic right();
    gesture_right = 1;
    cyc();
    gesture_right = 0;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic on,
                            input logic [3:0] win, input logic onp, input logic offp);
    checks++;
    assert ({pwr_state, sys_on, window_sec, on_pulse, off_pulse} === {st, on, win, onp, offp})
    else begin
      errors++;
      $error("FAIL %s: observed st=%0d sys_on=%b win=%0d on_p=%b off_p=%b, expected st=%0d sys_on=%b win=%0d on_p=%b off_p=%b",
             tag, pwr_state, sys_on, window_sec, on_pulse, off_pulse, st, on, win, onp, offp);
    end
  endtask

  initial begin
    cyc();
    cyc();
    expect_out("reset_state", 2'd0, 0, 4'd0, 0, 0);
    reset = 1;
    cyc();
    expect_out("idle_after_reset", 2'd0, 0, 4'd0, 0, 0);

    power_on = 1;
    cyc();
    expect_out("rise_on", 2'd2, 1, 4'd0, 1, 0);
    cyc();
    expect_out("rise_pulse_one_cycle", 2'd2, 1, 4'd0, 0, 0);
    power_on = 0;
    cyc();
    expect_out("fall_off", 2'd0, 0, 4'd0, 0, 1);
    cyc();
    expect_out("fall_pulse_one_cycle", 2'd0, 0, 4'd0, 0, 0);

    left();
    expect_out("arm_on_load", 2'd1, 0, 4'd5, 0, 0);
    ticks(99);
    expect_out("arm_on_tick99", 2'd1, 0, 4'd5, 0, 0);
    ticks(1);
    expect_out("arm_on_tick100", 2'd1, 0, 4'd4, 0, 0);
    ticks(200);
    expect_out("arm_on_tick300", 2'd1, 0, 4'd2, 0, 0);
    right();
    expect_out("gesture_on", 2'd2, 1, 4'd0, 1, 0);
    cyc();
    expect_out("gesture_on_settle", 2'd2, 1, 4'd0, 0, 0);

    left();
    expect_out("on_left_ignored", 2'd2, 1, 4'd0, 0, 0);
    right();
    expect_out("arm_off_load", 2'd3, 1, 4'd5, 0, 0);
    ticks(499);
    expect_out("arm_off_tick499", 2'd3, 1, 4'd1, 0, 0);
    left();
    expect_out("gesture_off", 2'd0, 0, 4'd0, 0, 1);

    right();
    expect_out("off_right_ignored", 2'd0, 0, 4'd0, 0, 0);
    left();
    ticks(499);
    expect_out("arm_on_before_expiry", 2'd1, 0, 4'd1, 0, 0);
    ticks(1);
    expect_out("arm_on_expiry", 2'd0, 0, 4'd0, 0, 0);

    gesture_left = 1;
    gesture_right = 1;
    cyc();
    gesture_left = 0;
    gesture_right = 0;
    expect_out("both_keys_ignored", 2'd0, 0, 4'd0, 0, 0);

    left();
    ticks(150);
    left();
    ticks(499);
    expect_out("arm_on_restart", 2'd1, 0, 4'd1, 0, 0);
    power_on = 1;
    gesture_right = 1;
    cyc();
    gesture_right = 0;
    expect_out("rise_with_right", 2'd2, 1, 4'd0, 1, 0);
    cyc();
    expect_out("rise_with_right_single", 2'd2, 1, 4'd0, 0, 0);

    right();
    ticks(500);
    expect_out("arm_off_expiry", 2'd2, 1, 4'd0, 0, 0);

    right();
    ticks(50);
    expect_out("arm_off_mid", 2'd3, 1, 4'd5, 0, 0);
    #2 reset = 0;
    #1;
    expect_out("async_reset", 2'd0, 0, 4'd0, 0, 0);
    power_on = 0;
    cyc();
    reset = 1;
    cyc();
    cyc();
    expect_out("no_pulse_after_reset", 2'd0, 0, 4'd0, 0, 0);

`ifdef POWER_AUTO_OFF_EN
    power_on = 1;
    cyc();
    expect_out("auto_on", 2'd2, 1, 4'd0, 1, 0);
    ticks(199);
    expect_out("auto_before", 2'd2, 1, 4'd0, 0, 0);
    ticks(1);
    expect_out("auto_off", 2'd0, 0, 4'd0, 0, 1);
    power_on = 0;
    cyc();
    cyc();
    power_on = 1;
    cyc();
    expect_out("auto_on_again", 2'd2, 1, 4'd0, 1, 0);
    ticks(149);
    tick = 1;
    activity = 1;
    cyc();
    tick = 0;
    activity = 0;
    cyc();
    ticks(199);
    expect_out("activity_delays", 2'd2, 1, 4'd0, 0, 0);
    ticks(1);
    expect_out("activity_auto_off", 2'd0, 0, 4'd0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
